// File: rtl/ssqa_pkg.sv
// Shared definitions for the annealing-core host side: loader FSM states,
// core state codes and the coefficient BRAM address width.
// No logic; constants and types only.
package ssqa_pkg;

    // Coefficient BRAM address width (covers NN*NN up to 2^20 words).
    localparam int LD_AW = 20;

    // Core 'state' output codes used by the loader; the core's schedulers
    // share the same encoding (IDLE=0 ... FIN=10).
    localparam logic [3:0] CS_IDLE = 4'd0;
    localparam logic [3:0] CS_FIN  = 4'd10;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LOAD,
        L_GUARD,
        L_ARM,
        L_RUN,
        L_DONE
    } ld_state_t;

endpackage

// File: rtl/bram_wr_port.sv
// Purpose: registers accepted stream beats onto the BRAM write port and owns the word address counter.
// Latency: beat accepted in cycle t -> ena/wea/addra/dina presented in cycle t+1 only.
// Backpressure: none; every beat_i is written, one word per cycle.
//
// Ports: clk/rst_n clock and async active-low reset; beat_i accepted handshake;
// last_i s_last of that beat; clr_i restarts the counter at 0; data_i beat data;
// tc_o counter sits on the final word; ena_o/wea_o/addra_o/dina_o BRAM port A.
module bram_wr_port
    import ssqa_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 640000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_i,
    input  logic             last_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             tc_o,
    output logic             ena_o,
    output logic             wea_o,
    output logic [LD_AW-1:0] addra_o,
    output logic [WIDTH-1:0] dina_o
);

    localparam logic [LD_AW-1:0] LAST_ADDR = LD_AW'(NWORDS - 1);

    logic [LD_AW-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [LD_AW-1:0] addra_q;
    logic [WIDTH-1:0] dina_q;

    assign tc_o = (cnt_q == LAST_ADDR);

    // Any beat that ends a load (good or bad) returns the counter to 0, so the
    // counter never wraps past NWORDS-1 even at the 2^20 limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (beat_i) begin
            if (last_i || tc_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + LD_AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            we_q  <= beat_i;
            if (beat_i) begin
                addra_q <= cnt_q;
                dina_q  <= data_i;
            end
        end
    end

    assign ena_o   = we_q;
    assign wea_o   = we_q;
    assign addra_o = addra_q;
    assign dina_o  = dina_q;

endmodule

// File: rtl/coef_loader.sv
// Purpose: loads J into the core's coefficient BRAM, launches a run and times it until FIN.
// Latency: start -> s_ready next cycle; last beat -> write t+1, comp_en t+2; FIN sampled -> done next cycle.
// Backpressure: s_ready is a registered state decode, high only while loading; never depends on s_valid.
//
// Ports: clk, rst_sys (async active-low); start/reload command; s_valid/s_ready/s_data/s_last
// J stream; ena/wea/addra/dina BRAM write port; comp_en run request; core_state from core;
// busy/done/err_len status; run_cycles run length in clocks (saturating).
module coef_loader
    import ssqa_pkg::*;
#(
    parameter int         WIDTH   = 4,
    parameter int         NWORDS  = 640000,
    parameter logic [3:0] ST_IDLE = CS_IDLE,
    parameter logic [3:0] ST_FIN  = CS_FIN
) (
    input  logic             clk,
    input  logic             rst_sys,
    input  logic             start,
    input  logic             reload,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             ena,
    output logic             wea,
    output logic [LD_AW-1:0] addra,
    output logic [WIDTH-1:0] dina,
    output logic             comp_en,
    input  logic [3:0]       core_state,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic [31:0]      run_cycles
);

    ld_state_t   state_q, state_d;
    logic        err_q, err_d;
    logic        rdy_q, cen_q, busy_q, done_q;
    logic [31:0] run_q;
    logic        beat, tc, clr_cnt;

    assign beat = s_valid && rdy_q;

    bram_wr_port #(
        .WIDTH  (WIDTH),
        .NWORDS (NWORDS)
    ) u_wr (
        .clk     (clk),
        .rst_n   (rst_sys),
        .beat_i  (beat),
        .last_i  (s_last),
        .clr_i   (clr_cnt),
        .data_i  (s_data),
        .tc_o    (tc),
        .ena_o   (ena),
        .wea_o   (wea),
        .addra_o (addra),
        .dina_o  (dina)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        clr_cnt = 1'b0;
        case (state_q)
            L_IDLE, L_DONE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (reload) begin
                        state_d = L_LOAD;
                        clr_cnt = 1'b1;
                    end else begin
                        state_d = L_GUARD;
                    end
                end
            end
            L_LOAD: begin
                if (beat) begin
                    if (s_last && tc) begin
                        state_d = L_GUARD;
                    end else if (s_last || tc) begin
                        // Mis-sized load: the word is still written, but no run is launched.
                        err_d   = 1'b1;
                        state_d = L_IDLE;
                    end
                end
            end
            // One dead cycle so the last BRAM write retires before the core reads.
            L_GUARD: state_d = L_ARM;
            L_ARM: begin
                if (core_state != ST_IDLE) begin
                    state_d = L_RUN;
                end
            end
            L_RUN: begin
                if (core_state == ST_FIN) begin
                    state_d = L_DONE;
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            state_q <= L_IDLE;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            // Status flags are decoded from the next state so they line up with it.
            rdy_q   <= (state_d == L_LOAD);
            cen_q   <= (state_d == L_ARM) || (state_d == L_RUN);
            busy_q  <= (state_d != L_IDLE) && (state_d != L_DONE);
            done_q  <= (state_d == L_DONE);
            // ARM is only entered from GUARD, so clearing here zeroes the count
            // for the first comp_en cycle; every comp_en cycle then adds one,
            // including the one in which FIN is sampled.
            if (state_q == L_GUARD) begin
                run_q <= '0;
            end else if ((state_q == L_ARM || state_q == L_RUN) && (run_q != '1)) begin
                run_q <= run_q + 32'd1;
            end
        end
    end

    assign s_ready    = rdy_q;
    assign comp_en    = cen_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_len    = err_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_coef_loader.sv
module tb_coef_loader;

    localparam int NW     = 16;
    localparam int W      = 4;
    localparam int LAUNCH = 3;    // core leaves IDLE this many cycles after comp_en
    localparam int RUNLEN = 100;  // then reaches FIN this many cycles later
    localparam int EXP_RUN = LAUNCH + RUNLEN + 1;

    logic          clk, rst_sys, start, reload;
    logic          s_valid, s_ready, s_last;
    logic [W-1:0]  s_data, dina;
    logic          ena, wea, comp_en, busy, done, err_len;
    logic [19:0]   addra;
    logic [3:0]    core_state;
    logic [31:0]   run_cycles;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int comp_hi = 0;
    int core_n;

    // reference model of the write stream
    logic          acc_q;
    logic [19:0]   exp_addr;
    logic [W-1:0]  exp_data;
    int            mdl_cnt;
    logic [19:0]   last_wr_addr;
    logic [W-1:0]  last_wr_data;

    coef_loader #(.WIDTH(W), .NWORDS(NW)) dut (
        .clk        (clk),
        .rst_sys    (rst_sys),
        .start      (start),
        .reload     (reload),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .comp_en    (comp_en),
        .core_state (core_state),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len),
        .run_cycles (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: n = cycles elapsed since comp_en went high.
    always @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) core_n <= 0;
        else          core_n <= comp_en ? core_n + 1 : 0;
    end
    assign core_state = (core_n >= LAUNCH + RUNLEN) ? 4'd10 :
                        (core_n >= LAUNCH)          ? 4'd3  : 4'd0;

    // Each accepted beat must appear as a write one cycle later at the next
    // word address of the current load; a load ends on s_last or word NW-1.
    always @(posedge clk or negedge rst_sys) begin
        if (!rst_sys) begin
            acc_q   <= 1'b0;
            mdl_cnt <= 0;
        end else begin
            acc_q <= s_valid && s_ready;
            if (s_valid && s_ready) begin
                exp_addr <= 20'(mdl_cnt);
                exp_data <= s_data;
                mdl_cnt  <= (s_last || mdl_cnt == NW - 1) ? 0 : mdl_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_sys === 1'b1) begin
            chk("wr_strobe", {30'd0, ena, wea}, {30'd0, acc_q, acc_q});
            if (acc_q) begin
                chk("wr_addr", 32'(addra), 32'(exp_addr));
                chk("wr_data", 32'(dina), 32'(exp_data));
                wr_cnt++;
                last_wr_addr = addra;
                last_wr_data = dina;
            end
            if (comp_en === 1'b1) comp_hi++;
            chk("cen_ready_excl", 32'(comp_en & s_ready), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic rl);
        start  = 1'b1;
        reload = rl;
        tick();
        start  = 1'b0;
        reload = 1'b0;
    endtask

    // Sends words first..n-1; s_last on index last_idx (-1: never).
    task automatic send_load(input int first, input int n, input int last_idx, input bit gappy);
        int  i;
        int  guard;
        bit  go;
        bit  acc;
        i = first;
        guard = 0;
        while (i < n && guard < 400) begin
            go      = !gappy || ($urandom_range(0, 1) == 1);
            s_valid = go;
            s_data  = gappy ? W'($urandom) : i[W-1:0];
            s_last  = go && (i == last_idx);
            acc     = go && (s_ready === 1'b1);
            tick();
            guard++;
            if (acc) i++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (i < n) chk("load_timeout", 32'(i), 32'(n));
    endtask

    task automatic check_launch(input string name);
        chk({name, "_cen_t1"}, 32'(comp_en), 32'd0);
        chk({name, "_rdy_t1"}, 32'(s_ready), 32'd0);
        tick();
        chk({name, "_cen_t2"}, 32'(comp_en), 32'd1);
    endtask

    task automatic wait_done(input string name, input int c0);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 500) begin
            tick();
            k++;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_cen_off"}, 32'(comp_en), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_run_lit"}, run_cycles, 32'(EXP_RUN));
        chk({name, "_run_mdl"}, run_cycles, 32'(comp_hi - c0));
    endtask

    int w0, c0;

    initial begin
        rst_sys = 1'b1;
        start = 1'b0; reload = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        #1 rst_sys = 1'b0;
        #1;
        chk("rst_flags", {25'd0, s_ready, ena, wea, comp_en, busy, done, err_len}, 32'd0);
        chk("rst_addra", 32'(addra), 32'd0);
        chk("rst_run", run_cycles, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_sys = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // full load, no gaps, data = index
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b1);
        chk("t1_rdy", 32'(s_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_load(0, NW, NW - 1, 1'b0);
        check_launch("t1");
        wait_done("t1", c0);
        chk("t1_writes", 32'(wr_cnt - w0), 32'(NW));
        chk("t1_last_addr", 32'(last_wr_addr), 32'd15);
        chk("t1_last_data", 32'(last_wr_data), 32'd15);

        // gappy stream, random data
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b1);
        chk("t2_done_clr", 32'(done), 32'd0);
        send_load(0, NW, NW - 1, 1'b1);
        check_launch("t2");
        wait_done("t2", c0);
        chk("t2_writes", 32'(wr_cnt - w0), 32'(NW));

        // early s_last on word 9
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b1);
        send_load(0, 10, 9, 1'b0);
        chk("t3_err", 32'(err_len), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_rdy", 32'(s_ready), 32'd0);
        repeat (6) tick();
        chk("t3_no_run", 32'(comp_hi - c0), 32'd0);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd10);
        chk("t3_err_hold", 32'(err_len), 32'd1);

        // missing s_last on the final word
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b1);
        chk("t3b_err_clr", 32'(err_len), 32'd0);
        send_load(0, NW, -1, 1'b1);
        tick();
        chk("t3b_err", 32'(err_len), 32'd1);
        chk("t3b_busy", 32'(busy), 32'd0);
        chk("t3b_writes", 32'(wr_cnt - w0), 32'(NW));
        chk("t3b_no_run", 32'(comp_hi - c0), 32'd0);

        // run without reload from IDLE: clears err_len
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b0);
        chk("t4_err_clr", 32'(err_len), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_cen_t1", 32'(comp_en), 32'd0);
        tick();
        chk("t4_cen_t2", 32'(comp_en), 32'd1);
        wait_done("t4", c0);
        chk("t4_writes", 32'(wr_cnt - w0), 32'd0);

        // run without reload from DONE, start during run ignored
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b0);
        chk("t5_cen_t1", 32'(comp_en), 32'd0);
        tick();
        chk("t5_cen_t2", 32'(comp_en), 32'd1);
        repeat (10) tick();
        pulse_start(1'b1);
        chk("t5_ign_rdy", 32'(s_ready), 32'd0);
        chk("t5_ign_busy", 32'(busy), 32'd1);
        chk("t5_ign_cen", 32'(comp_en), 32'd1);
        wait_done("t5", c0);
        chk("t5_writes", 32'(wr_cnt - w0), 32'd0);

        // reset in the middle of a load
        pulse_start(1'b1);
        send_load(0, 7, -1, 1'b0);
        s_valid = 1'b1; s_data = 4'd7; s_last = 1'b0;
        #2 rst_sys = 1'b0;
        #1;
        chk("t6_rst_flags", {25'd0, s_ready, ena, wea, comp_en, busy, done, err_len}, 32'd0);
        chk("t6_rst_addra", 32'(addra), 32'd0);
        chk("t6_rst_run", run_cycles, 32'd0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_sys = 1'b1;
        tick();
        w0 = wr_cnt; c0 = comp_hi;
        pulse_start(1'b1);
        s_valid = 1'b1; s_data = 4'd5; s_last = 1'b0;
        tick();
        chk("t6_first_we", 32'(wea), 32'd1);
        chk("t6_first_addr", 32'(addra), 32'd0);
        chk("t6_first_data", 32'(dina), 32'd5);
        send_load(1, NW, NW - 1, 1'b0);
        check_launch("t6");
        wait_done("t6", c0);
        chk("t6_writes", 32'(wr_cnt - w0), 32'(NW));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
